reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue of the out-of-order core. Decoder allocates one entry per issued
//  instruction; ALU/LSB results arrive on the CDB; head entries retire in program order onto the
//  regfile commit port (write_enabled/reg_id/data/rob_id) and the LSB store-commit port. A mispredicted
//  branch at head raises the core-wide flush. Drives the regfile's from_rob_* inputs.
// PARAMETERS
//  DEPTH   8   number of entries; must satisfy DEPTH <= 2**TAG_W - 1
//  TAG_W   4   ROB tag width; tag = entry index + 1; tag 0 = "no producer" (regfile convention)
// PORTS
//  clk_in                     in   1      system clock
//  rst_in                     in   1      asynchronous reset, active-high
//  from_decoder_valid         in   1      issue request
//  from_decoder_type          in   2      0=ALU/load (writes rd), 1=branch/jump, 2=store
//  from_decoder_rd            in   5      destination register (0 = none)
//  to_decoder_full            out  1      no free entry (combinational from count)
//  to_decoder_next_tag        out  TAG_W  tag the next accepted issue receives (tail+1)
//  cdb_valid                  in   1      result broadcast
//  cdb_tag                    in   TAG_W  producing entry
//  cdb_value                  in   32     result / link value
//  cdb_mispredict             in   1      branch resolved against prediction (branches only)
//  cdb_target                 in   32     correct next PC when cdb_mispredict
//  query_tag1, query_tag2     in   TAG_W  operand tags from regfile rob_id lookup
//  query_ready1, query_ready2 out  1      entry holds result (combinational)
//  query_value1, query_value2 out  32     entry result (combinational)
//  to_regfile_write_enabled   out  1      commit writes register
//  to_regfile_reg_id          out  5      committed rd
//  to_regfile_data            out  32     committed value
//  to_regfile_rob_id          out  TAG_W  tag of committed entry
//  to_lsb_store_commit        out  1      head store may write memory
//  to_lsb_store_tag           out  TAG_W  tag of committed store
//  flush_out                  out  1      pipeline flush pulse
//  redirect_pc                out  32     fetch restart PC, valid with flush_out
// BEHAVIOUR
//  - Reset (async): head=tail=count=0, all entries busy=0/ready=0, every output reg 0; full=0, next_tag=1.
//  - Issue: accepted when from_decoder_valid && !full && !flush_out; writes entry[tail] (busy=1,
//    ready=0, type, rd), tail<=tail+1 mod DEPTH. Full blocks issue even if a commit occurs same cycle.
//  - CDB: if cdb_valid && tag!=0 && entry[tag-1].busy: ready<=1, value/mispredict/target stored.
//    Tag 0 or non-busy entry ignored. Stores become ready via CDB (address/data resolved by LSB).
//  - Query: tag 0 -> ready=1, value=0. Else ready=entry.ready, value=entry.value; bypass: same-cycle
//    cdb_valid with matching tag -> ready=1, value=cdb_value.
//  - Commit: at most one per cycle when count!=0 and entry[head].ready. Outputs registered, pulse for
//    exactly one cycle after the retiring edge. type0/type1 with rd!=0 -> write_enabled=1, reg_id, data,
//    rob_id=head+1; rd==0 -> write_enabled=0. type2 -> store_commit=1, store_tag=head+1.
//    head<=head+1 mod DEPTH, busy cleared. Entry made ready by CDB retires no earlier than next cycle.
//  - Count: +1 on issue, -1 on commit, unchanged on both; pointer wrap at DEPTH-1 -> 0.
//  - Mispredict: retiring type1 with mispredict=1 also performs its rd write, then flush_out=1,
//    redirect_pc=target for one cycle; same edge clears all busy/ready, head=tail=count=0.
//    While flush_out=1, issue and CDB inputs are ignored; commit outputs in that cycle are only
//    those of the branch itself.
//  - Reset mid-operation discards all entries immediately; no commit or flush pulse follows.
// TESTING
//  - Reset then issue 3 type0 (rd=1,2,3): next_tag 1->2->3->4, count=3, full=0, no commit.
//  - CDB tag2=0xAA then tag1=0x55: nothing retires until tag1 ready; then rd1=0x55 (rob_id 1),
//    rd2=0xAA (rob_id 2) on consecutive cycles; rd3 waits.
//  - Fill 8 entries: full=1, 9th issue dropped, next_tag stays 1; commit one -> full=0; next issue
//    gets tag 1 (wrap).
//  - Query tag3 while cdb_valid tag3=0x1234 same cycle -> query_ready=1, query_value=0x1234.
//  - Branch at tag2 mispredict target 0x100, tags 3-5 issued: after tag1,2 commit, flush_out=1,
//    redirect_pc=0x100, count=0, next_tag=1; later CDB for tag4 ignored.
//  - Store at head made ready -> to_lsb_store_commit=1, store_tag=head+1, to_regfile_write_enabled=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order retirement queue.
// Entries are allocated at the tail by the decoder, marked ready by CDB
// broadcasts, and retired from the head in program order. Retirement drives
// the regfile commit port and the LSB store-commit port. A mispredicted branch
// reaching the head raises a one-cycle core-wide flush.
// Tags are entry index + 1; tag 0 means "no producer".
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  // decoder issue side
  input  logic             from_decoder_valid,
  input  logic [1:0]       from_decoder_type,
  input  logic [4:0]       from_decoder_rd,
  output logic             to_decoder_full,
  output logic [TAG_W-1:0] to_decoder_next_tag,
  // common data bus
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  // operand queries
  input  logic [TAG_W-1:0] query_tag1,
  input  logic [TAG_W-1:0] query_tag2,
  output logic             query_ready1,
  output logic             query_ready2,
  output logic [31:0]      query_value1,
  output logic [31:0]      query_value2,
  // regfile commit port
  output logic             to_regfile_write_enabled,
  output logic [4:0]       to_regfile_reg_id,
  output logic [31:0]      to_regfile_data,
  output logic [TAG_W-1:0] to_regfile_rob_id,
  // LSB store commit port
  output logic             to_lsb_store_commit,
  output logic [TAG_W-1:0] to_lsb_store_tag,
  // flush / redirect
  output logic             flush_out,
  output logic [31:0]      redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(DEPTH);

  typedef enum logic [1:0] {
    OP_ALU    = 2'd0,  // ALU op or load: writes rd
    OP_BRANCH = 2'd1,  // branch / jump: may write link register
    OP_STORE  = 2'd2,  // store: commits to memory via LSB
    OP_RSVD   = 2'd3
  } op_e;

  // Control state (reset)
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_ready;
  logic [DEPTH-1:0] r_mispred;

  // Payload storage (only read while the entry is busy/ready)
  op_e         r_type   [DEPTH];
  logic [4:0]  r_rd     [DEPTH];
  logic [31:0] r_value  [DEPTH];
  logic [31:0] r_target [DEPTH];

  // Registered commit / flush outputs
  logic             r_rf_we;
  logic [4:0]       r_rf_reg_id;
  logic [31:0]      r_rf_data;
  logic [TAG_W-1:0] r_rf_rob_id;
  logic             r_store_commit;
  logic [TAG_W-1:0] r_store_tag;
  logic             r_flush;
  logic [31:0]      r_redirect_pc;

  // Combinational control
  logic             w_full;
  logic             w_issue;
  logic [PTR_W-1:0] w_cdb_idx;
  logic             w_cdb_write;
  logic             w_commit;
  logic             w_mispredict;
  logic             w_commit_rf_we;
  logic             w_commit_store;
  logic [TAG_W-1:0] w_head_tag;
  logic [32:0]      w_query1;
  logic [32:0]      w_query2;

  // Circular pointer advance with wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_IDX) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Tag to entry index (caller guarantees tag is in range).
  function automatic logic [PTR_W-1:0] tag_to_idx(input logic [TAG_W-1:0] t);
    tag_to_idx = PTR_W'(t - TAG_W'(1));
  endfunction

  // A tag names a real entry when it is 1..DEPTH.
  function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
    tag_in_range = (t != '0) && (t <= MAX_TAG);
  endfunction

  // Operand lookup: {ready, value}. Tag 0 is always ready with value 0; a
  // same-cycle CDB broadcast of the tag bypasses the stored state.
  function automatic logic [32:0] query_lookup(input logic [TAG_W-1:0] t);
    logic [PTR_W-1:0] idx;
    idx = tag_to_idx(t);
    if (t == '0) begin
      query_lookup = {1'b1, 32'd0};
    end else if (cdb_valid && !r_flush && (cdb_tag == t)) begin
      query_lookup = {1'b1, cdb_value};
    end else if (tag_in_range(t)) begin
      query_lookup = {r_ready[idx], r_value[idx]};
    end else begin
      query_lookup = {1'b0, 32'd0};
    end
  endfunction

  // Issue, CDB capture and head retirement decisions.
  always_comb begin
    w_full         = (r_count == FULL_CNT);
    w_issue        = from_decoder_valid && !w_full && !r_flush;
    w_cdb_idx      = tag_to_idx(cdb_tag);
    w_cdb_write    = 1'b0;
    w_commit       = (r_count != '0) && r_ready[r_head] && !r_flush;
    w_head_tag     = TAG_W'(r_head) + TAG_W'(1);
    w_commit_rf_we = 1'b0;
    w_commit_store = 1'b0;
    w_mispredict   = 1'b0;
    if (cdb_valid && !r_flush && tag_in_range(cdb_tag)) begin
      w_cdb_write = r_busy[w_cdb_idx];
    end else begin
      w_cdb_write = 1'b0;
    end
    case (r_type[r_head])
      OP_ALU: begin
        w_commit_rf_we = w_commit && (r_rd[r_head] != 5'd0);
      end
      OP_BRANCH: begin
        w_commit_rf_we = w_commit && (r_rd[r_head] != 5'd0);
        w_mispredict   = w_commit && r_mispred[r_head];
      end
      OP_STORE: begin
        w_commit_store = w_commit;
      end
      default: begin
        w_commit_rf_we = 1'b0;
        w_commit_store = 1'b0;
      end
    endcase
  end

  // Operand query ports.
  always_comb begin
    w_query1     = query_lookup(query_tag1);
    w_query2     = query_lookup(query_tag2);
    query_ready1 = w_query1[32];
    query_value1 = w_query1[31:0];
    query_ready2 = w_query2[32];
    query_value2 = w_query2[31:0];
  end

  // Pointers, occupancy and per-entry status; a retiring mispredict wipes all.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_ready   <= '0;
      r_mispred <= '0;
    end else if (w_mispredict) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_ready   <= '0;
      r_mispred <= '0;
    end else begin
      if (w_issue) begin
        r_busy[r_tail]    <= 1'b1;
        r_ready[r_tail]   <= 1'b0;
        r_mispred[r_tail] <= 1'b0;
        r_tail            <= ptr_inc(r_tail);
      end
      if (w_cdb_write) begin
        r_ready[w_cdb_idx]   <= 1'b1;
        r_mispred[w_cdb_idx] <= cdb_mispredict;
      end
      // Retirement clears the head last so it wins over any late CDB write.
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= ptr_inc(r_head);
      end
      case ({w_issue, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload: decode info at issue, result and redirect target from CDB.
  always_ff @(posedge clk_in) begin
    if (w_issue) begin
      r_type[r_tail] <= op_e'(from_decoder_type);
      r_rd[r_tail]   <= from_decoder_rd;
    end
    if (w_cdb_write) begin
      r_value[w_cdb_idx]  <= cdb_value;
      r_target[w_cdb_idx] <= cdb_target;
    end
  end

  // Registered commit and flush pulses, one cycle after the retiring edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rf_we        <= 1'b0;
      r_rf_reg_id    <= '0;
      r_rf_data      <= '0;
      r_rf_rob_id    <= '0;
      r_store_commit <= 1'b0;
      r_store_tag    <= '0;
      r_flush        <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_rf_we        <= w_commit_rf_we;
      r_rf_reg_id    <= w_commit_rf_we ? r_rd[r_head]    : 5'd0;
      r_rf_data      <= w_commit_rf_we ? r_value[r_head] : 32'd0;
      r_rf_rob_id    <= w_commit_rf_we ? w_head_tag      : '0;
      r_store_commit <= w_commit_store;
      r_store_tag    <= w_commit_store ? w_head_tag      : '0;
      r_flush        <= w_mispredict;
      r_redirect_pc  <= w_mispredict ? r_target[r_head] : 32'd0;
    end
  end

  assign to_decoder_full          = w_full;
  assign to_decoder_next_tag      = TAG_W'(r_tail) + TAG_W'(1);
  assign to_regfile_write_enabled = r_rf_we;
  assign to_regfile_reg_id        = r_rf_reg_id;
  assign to_regfile_data          = r_rf_data;
  assign to_regfile_rob_id        = r_rf_rob_id;
  assign to_lsb_store_commit      = r_store_commit;
  assign to_lsb_store_tag         = r_store_tag;
  assign flush_out                = r_flush;
  assign redirect_pc              = r_redirect_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: a vector table for the basic
// issue / CDB / query / commit flow, plus hand-written sequences for full/wrap,
// mispredict flush and mid-operation reset.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        from_decoder_valid;
  logic [1:0]  from_decoder_type;
  logic [4:0]  from_decoder_rd;
  logic        to_decoder_full;
  logic [3:0]  to_decoder_next_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  query_tag1, query_tag2;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        to_regfile_write_enabled;
  logic [4:0]  to_regfile_reg_id;
  logic [31:0] to_regfile_data;
  logic [3:0]  to_regfile_rob_id;
  logic        to_lsb_store_commit;
  logic [3:0]  to_lsb_store_tag;
  logic        flush_out;
  logic [31:0] redirect_pc;

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer #(.DEPTH(8), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .from_decoder_valid(from_decoder_valid), .from_decoder_type(from_decoder_type),
    .from_decoder_rd(from_decoder_rd), .to_decoder_full(to_decoder_full),
    .to_decoder_next_tag(to_decoder_next_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .query_tag1(query_tag1), .query_tag2(query_tag2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .to_regfile_write_enabled(to_regfile_write_enabled),
    .to_regfile_reg_id(to_regfile_reg_id), .to_regfile_data(to_regfile_data),
    .to_regfile_rob_id(to_regfile_rob_id),
    .to_lsb_store_commit(to_lsb_store_commit), .to_lsb_store_tag(to_lsb_store_tag),
    .flush_out(flush_out), .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        iv;    logic [1:0] ity;  logic [4:0]  ird;
    logic        cv;    logic [3:0] ctag; logic [31:0] cval;
    logic [3:0]  qt;    logic       eqr;  logic [31:0] eqv;
    logic        efull; logic [3:0] entag;
    logic        ewe;   logic [4:0] erd;  logic [31:0] edata; logic [3:0] erob;
    logic        esc;   logic [3:0] estag;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(
    input logic iv, input logic [1:0] ity, input logic [4:0] ird,
    input logic cv, input logic [3:0] ctag, input logic [31:0] cval,
    input logic [3:0] qt, input logic eqr, input logic [31:0] eqv,
    input logic efull, input logic [3:0] entag,
    input logic ewe, input logic [4:0] erd, input logic [31:0] edata, input logic [3:0] erob,
    input logic esc, input logic [3:0] estag);
    vec_t v;
    v.iv = iv; v.ity = ity; v.ird = ird; v.cv = cv; v.ctag = ctag; v.cval = cval;
    v.qt = qt; v.eqr = eqr; v.eqv = eqv; v.efull = efull; v.entag = entag;
    v.ewe = ewe; v.erd = erd; v.edata = edata; v.erob = erob; v.esc = esc; v.estag = estag;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [1:0] ty, input logic [4:0] rd,
                        input logic cv, input logic [3:0] ct, input logic [31:0] cval,
                        input logic mp, input logic [31:0] tg);
    from_decoder_valid = iv;
    from_decoder_type  = ty;
    from_decoder_rd    = rd;
    cdb_valid          = cv;
    cdb_tag            = ct;
    cdb_value          = cval;
    cdb_mispredict     = mp;
    cdb_target         = tg;
  endtask

  task automatic idle();
    set_in(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    idle();
    query_tag1 = 4'd0;
    query_tag2 = 4'd0;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // iv ty rd | cv ctag cval | qt eqr eqv | full ntag | we rd data rob | sc stag
    vecs[0]  = mk(1'b1, 2'd0, 5'd1, 1'b0, 4'd0, 32'h0,    4'd1, 1'b0, 32'h0,    1'b0, 4'd2, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[1]  = mk(1'b1, 2'd0, 5'd2, 1'b0, 4'd0, 32'h0,    4'd1, 1'b0, 32'h0,    1'b0, 4'd3, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[2]  = mk(1'b1, 2'd0, 5'd3, 1'b0, 4'd0, 32'h0,    4'd0, 1'b1, 32'h0,    1'b0, 4'd4, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[3]  = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd2, 32'hAA,   4'd2, 1'b1, 32'hAA,   1'b0, 4'd4, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[4]  = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'h55,   4'd2, 1'b1, 32'hAA,   1'b0, 4'd4, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[5]  = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd1, 1'b1, 32'h55,   1'b0, 4'd4, 1'b1, 5'd1, 32'h55,   4'd1, 1'b0, 4'd0);
    vecs[6]  = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd3, 1'b0, 32'h0,    1'b0, 4'd4, 1'b1, 5'd2, 32'hAA,   4'd2, 1'b0, 4'd0);
    vecs[7]  = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd3, 32'h1234, 4'd3, 1'b1, 32'h1234, 1'b0, 4'd4, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[8]  = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd3, 1'b1, 32'h1234, 1'b0, 4'd4, 1'b1, 5'd3, 32'h1234, 4'd3, 1'b0, 4'd0);
    vecs[9]  = mk(1'b1, 2'd2, 5'd0, 1'b0, 4'd0, 32'h0,    4'd4, 1'b0, 32'h0,    1'b0, 4'd5, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[10] = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd4, 32'h0,    4'd4, 1'b1, 32'h0,    1'b0, 4'd5, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[11] = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd4, 1'b1, 32'h0,    1'b0, 4'd5, 1'b0, 5'd0, 32'h0,    4'd0, 1'b1, 4'd4);
    vecs[12] = mk(1'b1, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd0, 1'b1, 32'h0,    1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[13] = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd5, 32'h77,   4'd5, 1'b1, 32'h77,   1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[14] = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd5, 1'b1, 32'h77,   1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[15] = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd7, 32'h99,   4'd7, 1'b1, 32'h99,   1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[16] = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd7, 1'b0, 32'h0,    1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[17] = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd0, 32'h33,   4'd0, 1'b1, 32'h0,    1'b0, 4'd6, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[18] = mk(1'b1, 2'd1, 5'd9, 1'b0, 4'd0, 32'h0,    4'd6, 1'b0, 32'h0,    1'b0, 4'd7, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[19] = mk(1'b0, 2'd0, 5'd0, 1'b1, 4'd6, 32'h600,  4'd6, 1'b1, 32'h600,  1'b0, 4'd7, 1'b0, 5'd0, 32'h0,    4'd0, 1'b0, 4'd0);
    vecs[20] = mk(1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'h0,    4'd6, 1'b1, 32'h600,  1'b0, 4'd7, 1'b1, 5'd9, 32'h600,  4'd6, 1'b0, 4'd0);

    // Reset state
    do_reset();
    check("rst_full",     32'(to_decoder_full), 32'd0);
    check("rst_next_tag", 32'(to_decoder_next_tag), 32'd1);
    check("rst_we",       32'(to_regfile_write_enabled), 32'd0);
    check("rst_rob_id",   32'(to_regfile_rob_id), 32'd0);
    check("rst_store",    32'(to_lsb_store_commit), 32'd0);
    check("rst_flush",    32'(flush_out), 32'd0);
    check("rst_pc",       redirect_pc, 32'd0);

    // Table-driven flow
    for (int i = 0; i < 21; i++) begin
      set_in(vecs[i].iv, vecs[i].ity, vecs[i].ird, vecs[i].cv, vecs[i].ctag, vecs[i].cval, 1'b0, 32'd0);
      query_tag1 = vecs[i].qt;
      #1;
      check($sformatf("v%0d_qready", i), 32'(query_ready1), 32'(vecs[i].eqr));
      check($sformatf("v%0d_qvalue", i), query_value1, vecs[i].eqv);
      step();
      check($sformatf("v%0d_full", i),  32'(to_decoder_full), 32'(vecs[i].efull));
      check($sformatf("v%0d_ntag", i),  32'(to_decoder_next_tag), 32'(vecs[i].entag));
      check($sformatf("v%0d_we", i),    32'(to_regfile_write_enabled), 32'(vecs[i].ewe));
      check($sformatf("v%0d_sc", i),    32'(to_lsb_store_commit), 32'(vecs[i].esc));
      check($sformatf("v%0d_flush", i), 32'(flush_out), 32'd0);
      if (vecs[i].ewe) begin
        check($sformatf("v%0d_reg_id", i), 32'(to_regfile_reg_id), 32'(vecs[i].erd));
        check($sformatf("v%0d_data", i),   to_regfile_data, vecs[i].edata);
        check($sformatf("v%0d_rob_id", i), 32'(to_regfile_rob_id), 32'(vecs[i].erob));
      end
      if (vecs[i].esc) begin
        check($sformatf("v%0d_stag", i), 32'(to_lsb_store_tag), 32'(vecs[i].estag));
      end
    end
    idle();

    // Fill to DEPTH, drop the 9th issue, commit one, wrap to tag 1
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 2'd0, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      step();
    end
    check("fill_full", 32'(to_decoder_full), 32'd1);
    check("fill_ntag", 32'(to_decoder_next_tag), 32'd1);
    set_in(1'b1, 2'd0, 5'd20, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    step();
    check("drop9_full", 32'(to_decoder_full), 32'd1);
    check("drop9_ntag", 32'(to_decoder_next_tag), 32'd1);
    set_in(1'b1, 2'd0, 5'd20, 1'b1, 4'd1, 32'h10, 1'b0, 32'd0);
    step();
    set_in(1'b1, 2'd0, 5'd20, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    step();
    check("full_commit_we",   32'(to_regfile_write_enabled), 32'd1);
    check("full_commit_rob",  32'(to_regfile_rob_id), 32'd1);
    check("full_commit_data", to_regfile_data, 32'h10);
    check("full_commit_full", 32'(to_decoder_full), 32'd0);
    check("full_commit_ntag", 32'(to_decoder_next_tag), 32'd1);
    set_in(1'b1, 2'd0, 5'd21, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    step();
    check("wrap_full", 32'(to_decoder_full), 32'd1);
    check("wrap_ntag", 32'(to_decoder_next_tag), 32'd2);
    idle();
    query_tag2 = 4'd2;
    #1;
    check("q2_busy_ready", 32'(query_ready2), 32'd0);
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd2, 32'h22, 1'b0, 32'd0);
    #1;
    check("q2_bypass_ready", 32'(query_ready2), 32'd1);
    check("q2_bypass_value", query_value2, 32'h22);
    step();
    idle();
    #1;
    check("q2_stored_value", query_value2, 32'h22);

    // Mispredicted branch at tag 2 with younger tags 3..5
    do_reset();
    set_in(1'b1, 2'd0, 5'd1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b1, 2'd1, 5'd5, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b1, 2'd0, 5'd3, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b1, 2'd0, 5'd4, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b1, 2'd0, 5'd6, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    check("mp_ntag_pre", 32'(to_decoder_next_tag), 32'd6);
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'h11, 1'b0, 32'd0); step();
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd2, 32'h200, 1'b1, 32'h100); step();
    check("mp_c1_we",    32'(to_regfile_write_enabled), 32'd1);
    check("mp_c1_rob",   32'(to_regfile_rob_id), 32'd1);
    check("mp_c1_flush", 32'(flush_out), 32'd0);
    idle(); step();
    check("mp_br_we",    32'(to_regfile_write_enabled), 32'd1);
    check("mp_br_rd",    32'(to_regfile_reg_id), 32'd5);
    check("mp_br_data",  to_regfile_data, 32'h200);
    check("mp_br_rob",   32'(to_regfile_rob_id), 32'd2);
    check("mp_flush",    32'(flush_out), 32'd1);
    check("mp_pc",       redirect_pc, 32'h100);
    check("mp_ntag",     32'(to_decoder_next_tag), 32'd1);
    check("mp_full",     32'(to_decoder_full), 32'd0);
    set_in(1'b1, 2'd0, 5'd7, 1'b1, 4'd4, 32'h444, 1'b0, 32'd0); step();
    check("mp_after_flush",  32'(flush_out), 32'd0);
    check("mp_issue_ignored", 32'(to_decoder_next_tag), 32'd1);
    check("mp_after_we",     32'(to_regfile_write_enabled), 32'd0);
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd4, 32'h555, 1'b0, 32'd0); step();
    idle();
    query_tag1 = 4'd4;
    #1;
    check("mp_tag4_ignored", 32'(query_ready1), 32'd0);
    step();
    check("mp_tag4_no_commit", 32'(to_regfile_write_enabled), 32'd0);
    set_in(1'b1, 2'd0, 5'd8, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    check("mp_restart_ntag", 32'(to_decoder_next_tag), 32'd2);
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'h88, 1'b0, 32'd0); step();
    idle(); step();
    check("mp_restart_we",   32'(to_regfile_write_enabled), 32'd1);
    check("mp_restart_rob",  32'(to_regfile_rob_id), 32'd1);
    check("mp_restart_data", to_regfile_data, 32'h88);

    // Reset mid-operation while head is ready to retire
    do_reset();
    set_in(1'b1, 2'd0, 5'd1, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b1, 2'd0, 5'd2, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0); step();
    set_in(1'b0, 2'd0, 5'd0, 1'b1, 4'd1, 32'hDD, 1'b0, 32'd0); step();
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    check("mid_rst_ntag", 32'(to_decoder_next_tag), 32'd1);
    check("mid_rst_full", 32'(to_decoder_full), 32'd0);
    step();
    rst_in = 1'b0;
    query_tag1 = 4'd1;
    #1;
    check("mid_rst_query", 32'(query_ready1), 32'd0);
    step();
    step();
    check("mid_rst_we",    32'(to_regfile_write_enabled), 32'd0);
    check("mid_rst_flush", 32'(flush_out), 32'd0);
    check("mid_rst_ntag2", 32'(to_decoder_next_tag), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
